// File: rtl/divider_pkg.sv
// Shared definitions for the divider result path (controller writer and reader).
package divider_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ADDR   = 3'd1,
        ST_RD_WAIT1  = 3'd2,
        ST_RD_WAIT2  = 3'd3,
        ST_OUT_VALID = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    // Result region layout, shared with the divider scratch-memory controller.
    localparam int unsigned RESULT_BASE_ADDR = 129;
    localparam int unsigned RESULT_NUM_LINES = 64;

    localparam int unsigned DIV_LANES  = 8;
    localparam int unsigned DIV_LANE_W = 16;
    localparam int unsigned DIV_OUT_W  = 8;
    localparam int unsigned DIV_ADDR_W = 16;
    localparam int unsigned MAP_IDX_W  = 6;

endpackage

// File: rtl/div_lane_sat.sv
// Unsigned saturator: clamps one divider result to the output pixel width.
module div_lane_sat #(
    parameter int unsigned LANE_W = 16,
    parameter int unsigned OUT_W  = 8
) (
    input  logic [LANE_W-1:0] lane_i,
    output logic [OUT_W-1:0]  sat_c
);

    // Any set bit above the output width means the value exceeds the max code.
    always_comb begin
        sat_c = lane_i[OUT_W-1:0];
        if (|lane_i[LANE_W-1:OUT_W]) begin
            sat_c = '1;
        end
    end

endmodule

// File: rtl/divider_result_reader.sv
// Reads back the divider equalisation lines from scratch memory, saturates each
// lane and streams the lines to the remap stage over valid/ready.
module divider_result_reader
    import divider_pkg::*;
#(
    parameter int unsigned LANES     = DIV_LANES,
    parameter int unsigned LANE_W    = DIV_LANE_W,
    parameter int unsigned OUT_W     = DIV_OUT_W,
    parameter int unsigned BASE_ADDR = RESULT_BASE_ADDR,
    parameter int unsigned NUM_LINES = RESULT_NUM_LINES,
    parameter int unsigned ADDR_W    = DIV_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [ADDR_W-1:0]         sc_mem_rd_addr,
    input  logic [LANES*LANE_W-1:0]   sc_mem_rd_data,
    output logic                      map_valid,
    input  logic                      map_ready,
    output logic [LANES*OUT_W-1:0]    map_data,
    output logic [MAP_IDX_W-1:0]      map_index,
    output logic                      busy,
    output logic                      rd_done
);

    localparam int unsigned IDX_W = MAP_IDX_W;
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(NUM_LINES - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          line_q, line_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      map_valid_q, map_valid_d;
    logic [LANES*OUT_W-1:0]    map_data_q, map_data_d;
    logic [IDX_W-1:0]          map_index_q, map_index_d;
    logic                      busy_q, busy_d;
    logic                      rd_done_q, rd_done_d;
    logic [LANES*OUT_W-1:0]    sat_data_c;

    // Per-lane saturation of the raw scratch read data.
    for (genvar i = 0; i < LANES; i++) begin : g_sat
        div_lane_sat #(
            .LANE_W (LANE_W),
            .OUT_W  (OUT_W)
        ) u_sat (
            .lane_i (sc_mem_rd_data[i*LANE_W +: LANE_W]),
            .sat_c  (sat_data_c[i*OUT_W +: OUT_W])
        );
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        addr_d      = addr_q;
        map_valid_d = map_valid_q;
        map_data_d  = map_data_q;
        map_index_d = map_index_q;
        busy_d      = busy_q;
        rd_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD_ADDR;
                    line_d  = '0;
                    addr_d  = ADDR_W'(BASE_ADDR);
                    busy_d  = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_WAIT1;
            end
            ST_RD_WAIT1: begin
                state_d = ST_RD_WAIT2;
            end
            ST_RD_WAIT2: begin
                // Read data arrives now (two-cycle memory latency).
                map_data_d  = sat_data_c;
                map_index_d = line_q;
                map_valid_d = 1'b1;
                state_d     = ST_OUT_VALID;
            end
            ST_OUT_VALID: begin
                if (map_ready) begin
                    map_valid_d = 1'b0;
                    if (line_q == LAST_LINE) begin
                        rd_done_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        line_d  = line_q + IDX_W'(1);
                        addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(line_q) + ADDR_W'(1);
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            line_q      <= '0;
            addr_q      <= '0;
            map_valid_q <= 1'b0;
            map_data_q  <= '0;
            map_index_q <= '0;
            busy_q      <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            addr_q      <= addr_d;
            map_valid_q <= map_valid_d;
            map_data_q  <= map_data_d;
            map_index_q <= map_index_d;
            busy_q      <= busy_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign sc_mem_rd_addr = addr_q;
    assign map_valid      = map_valid_q;
    assign map_data       = map_data_q;
    assign map_index      = map_index_q;
    assign busy           = busy_q;
    assign rd_done        = rd_done_q;

endmodule

// File: tb/tb_divider_result_reader.sv
// Directed bench for divider_result_reader with a two-cycle-latency scratch model.
module tb_divider_result_reader;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   sc_mem_rd_addr;
    logic [127:0]  sc_mem_rd_data;
    logic          map_valid;
    logic          map_ready = 1'b1;
    logic [63:0]   map_data;
    logic [5:0]    map_index;
    logic          busy;
    logic          rd_done;

    int n_tests = 0;
    int n_fail  = 0;

    divider_result_reader dut (
        .clk            (clk),
        .reset          (rst_n),
        .start          (start),
        .sc_mem_rd_addr (sc_mem_rd_addr),
        .sc_mem_rd_data (sc_mem_rd_data),
        .map_valid      (map_valid),
        .map_ready      (map_ready),
        .map_data       (map_data),
        .map_index      (map_index),
        .busy           (busy),
        .rd_done        (rd_done)
    );

    always #5 clk = ~clk;

    // Scratch memory: address registered by the DUT, data two edges later.
    logic [127:0] mem [0:255];
    logic [127:0] rd_p1;
    always @(posedge clk) begin
        rd_p1          <= mem[sc_mem_rd_addr[7:0]];
        sc_mem_rd_data <= rd_p1;
    end

    // Edge counter; at a negedge it holds the number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: handshakes, address changes, valid rises, done pulses.
    logic [5:0]  hs_idx[$];
    logic [63:0] hs_data[$];
    int          hs_cyc[$];
    logic [15:0] addr_log[$];
    int          vrise_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [15:0] last_addr = 16'd0;
    logic        last_valid = 1'b0;

    always @(negedge clk) begin
        if (map_valid && map_ready) begin
            hs_idx.push_back(map_index);
            hs_data.push_back(map_data);
            hs_cyc.push_back(cyc);
        end
        if (sc_mem_rd_addr !== last_addr) begin
            addr_log.push_back(sc_mem_rd_addr);
            last_addr = sc_mem_rd_addr;
        end
        if (map_valid && !last_valid) vrise_cyc.push_back(cyc);
        last_valid = map_valid;
        if (rd_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    logic [63:0] exp_data [0:63];

    task automatic check_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        hs_idx.delete();
        hs_data.delete();
        hs_cyc.delete();
        addr_log.delete();
        vrise_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_v({tag, " addr"},  64'(sc_mem_rd_addr), 64'd0);
        check_v({tag, " valid"}, 64'(map_valid), 64'd0);
        check_v({tag, " data"},  map_data, 64'd0);
        check_v({tag, " index"}, 64'(map_index), 64'd0);
        check_v({tag, " busy"},  64'(busy), 64'd0);
        check_v({tag, " done"},  64'(rd_done), 64'd0);
    endtask

    // Pulse start for one cycle; k = edge count of the edge that samples it.
    task automatic pulse_start(output int k);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (rnd) map_ready = 1'($urandom_range(0, 1));
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_i("done_seen", int'(ok), 1);
        map_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_lines(input string tag);
        int n;
        check_i({tag, " line_count"}, hs_idx.size(), 64);
        n = (hs_idx.size() < 64) ? hs_idx.size() : 64;
        for (int i = 0; i < n; i++) begin
            check_v($sformatf("%s idx%0d", tag, i), 64'(hs_idx[i]), 64'(i));
            check_v($sformatf("%s data%0d", tag, i), hs_data[i], exp_data[i]);
        end
        check_i({tag, " rd_done_count"}, done_cnt, 1);
    endtask

    initial begin
        int k;
        bit found;
        logic [15:0] lanes [0:7];

        // Line n holds n in every lane; expected output is n in every byte.
        for (int a = 0; a < 256; a++) mem[a] = '0;
        for (int n = 0; n < 64; n++) begin
            logic [7:0] b;
            b = 8'(n);
            mem[129 + n] = {8{16'(n)}};
            exp_data[n]  = {8{b}};
        end

        // Reset state.
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Full run with ready held high: order, data, addresses, latency.
        clear_mon();
        pulse_start(k);
        wait_done(1'b0, 400);
        check_lines("full");
        check_i("addr_count", addr_log.size(), 64);
        for (int i = 0; i < addr_log.size() && i < 64; i++)
            check_v($sformatf("addr%0d", i), 64'(addr_log[i]), 64'(129 + i));
        // Edge k samples start; OUT_VALID is entered at edge k+3 (cycle k+4),
        // DONE at edge k+256 (cycle k+257).
        check_i("first_valid_latency", (vrise_cyc.size() > 0) ? vrise_cyc[0] - k : -1, 3);
        check_i("done_latency", done_cyc - k, 256);
        check_i("line_period", (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1, 4);
        check_v("busy_after_done", 64'(busy), 64'd0);

        // Saturation on line 0.
        lanes = '{16'd255, 16'd256, 16'hFFFF, 16'd17, 16'h8000, 16'd0, 16'd1, 16'h01FE};
        for (int i = 0; i < 8; i++) mem[129][i*16 +: 16] = lanes[i];
        exp_data[0] = 64'hFF_01_00_FF_11_FF_FF_FF;
        clear_mon();
        pulse_start(k);
        wait_done(1'b0, 400);
        check_lines("sat");

        // Back-pressure on line 5 for 10 cycles.
        clear_mon();
        pulse_start(k);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (map_valid && map_index == 6'd5) begin
                found = 1'b1;
                break;
            end
        end
        check_i("stall_found_line5", int'(found), 1);
        map_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_v($sformatf("stall valid c%0d", c), 64'(map_valid), 64'd1);
            check_v($sformatf("stall index c%0d", c), 64'(map_index), 64'd5);
            check_v($sformatf("stall data c%0d", c), map_data, exp_data[5]);
            check_v($sformatf("stall addr c%0d", c), 64'(sc_mem_rd_addr), 64'd134);
            @(posedge clk); #1;
        end
        map_ready = 1'b1;
        wait_done(1'b0, 400);
        check_lines("stall");

        // Extra start pulses while busy and in the DONE cycle are ignored.
        clear_mon();
        pulse_start(k);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (map_valid && map_index == 6'd20) begin
                found = 1'b1;
                break;
            end
        end
        check_i("restart_found_line20", int'(found), 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (rd_done) begin
                found = 1'b1;
                break;
            end
        end
        check_i("restart_found_done", int'(found), 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_v("restart busy", 64'(busy), 64'd0);
        check_v("restart valid", 64'(map_valid), 64'd0);
        check_i("restart addr_count", addr_log.size(), 64);
        check_lines("restart");

        // Asynchronous reset in the middle of line 30.
        clear_mon();
        pulse_start(k);
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (map_valid && map_index == 6'd30) begin
                found = 1'b1;
                break;
            end
        end
        check_i("rst_found_line30", int'(found), 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_v("midrst idle busy", 64'(busy), 64'd0);
        check_i("midrst no done", done_cnt, 0);
        clear_mon();
        pulse_start(k);
        wait_done(1'b0, 400);
        check_v("midrst first addr", (addr_log.size() > 0) ? 64'(addr_log[0]) : 64'hDEAD, 64'd129);
        check_lines("after_rst");

        // Random ready, half duty.
        clear_mon();
        pulse_start(k);
        wait_done(1'b1, 3000);
        check_lines("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_result_reader.md
Name: divider_result_reader

Overview:
- Reads the equalisation mapping written by the divider scratch-memory controller. That controller writes 64 lines of 8 divider results to scratch addresses 129..192.
- After the write-done pulse, this block reads the lines back, saturates each lane to the output pixel width, and streams them to the pixel remap stage.
- Uses a valid/ready handshake on the output.
- It is the reader for the divider write path and sits between scratch memory and the remap unit.

Parameters:
- LANES, 8, divider results per scratch line.
- LANE_W, 16, width of one divider result in scratch memory.
- OUT_W, 8, width of one mapped output value.
- BASE_ADDR, 129, scratch address of the first result line.
- NUM_LINES, 64, result lines to read.
- ADDR_W, 16, scratch address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  one-cycle pulse; driven by the divider controller's sc_mem_wt_done.
- sc_mem_rd_addr  out  ADDR_W  scratch read address (registered).
- sc_mem_rd_data  in  LANES*LANE_W  scratch read data; lane i is bits [i*LANE_W +: LANE_W].
- map_valid  out  1  map_data / map_index are valid.
- map_ready  in  1  downstream accepts the current line.
- map_data  out  LANES*OUT_W  saturated lanes; lane i is bits [i*OUT_W +: OUT_W].
- map_index  out  6  line number 0..NUM_LINES-1 of map_data.
- busy  out  1  high from the cycle after start is accepted until done.
- rd_done  out  1  one-cycle pulse after the last line is accepted.

Behaviour:
- Reset values: all outputs 0 (sc_mem_rd_addr=0, map_valid=0, map_data=0, map_index=0, busy=0, rd_done=0); state IDLE; line counter 0.
- Reset may assert at any time. It returns the block to IDLE immediately, no rd_done, with outputs at reset values.
- States are IDLE, RD_ADDR, RD_WAIT1, RD_WAIT2, OUT_VALID, DONE.
- IDLE:
  - start=1 -> RD_ADDR, line=0, busy=1.
  - start=0 -> stay in IDLE.
- RD_ADDR: sc_mem_rd_addr = BASE_ADDR + line, valid during this cycle; -> RD_WAIT1.
- RD_WAIT1: address held; -> RD_WAIT2.
- RD_WAIT2:
  - Scratch memory has 2-cycle read latency, so sc_mem_rd_data is valid in this cycle.
  - It is captured on the clock edge leaving this state into the saturated output register.
  - map_index = line; -> OUT_VALID.
- OUT_VALID:
  - map_valid=1; map_data and map_index are held stable while map_ready=0.
  - On map_valid & map_ready:
    - If line == NUM_LINES-1: map_valid=0, -> DONE.
    - Otherwise: line+1, map_valid=0, -> RD_ADDR.
- DONE: rd_done=1 for exactly one cycle; busy=0 on exit; -> IDLE.
- Saturation, per lane, unsigned: if lane > 2^OUT_W-1, out = 2^OUT_W-1; otherwise out = lane[OUT_W-1:0].
- Latency:
  - start sampled at edge k; RD_ADDR in cycle k+1; first map_valid in cycle k+4.
  - With map_ready held at 1, one line per 4 cycles.
  - 64 lines take 256 cycles; rd_done in cycle k+257.
- start while busy (any state other than IDLE) is ignored and does not restart.
- start in the same cycle as the DONE pulse is ignored. Only start sampled in IDLE is accepted.
- The line counter never wraps. The address sequence is exactly BASE_ADDR .. BASE_ADDR+NUM_LINES-1 (129..192).
- map_ready while map_valid=0 has no effect.

Decomposition:
- Shared package divider_pkg holds:
  - state encoding (3-bit localparams);
  - RESULT_BASE_ADDR=129 and RESULT_NUM_LINES=64, shared with the divider controller;
  - LANES, LANE_W.
- One sub-module, div_lane_sat: combinational LANE_W -> OUT_W unsigned saturator, instantiated LANES times by generate.
- The FSM, counter and output register stay in the top module.

Test Plan:
- Preload line n with all lanes = n; pulse start; map_ready=1 -> 64 handshakes; map_index 0..63 in order; lanes = n; addresses 129..192; first map_valid 4 cycles after start; rd_done once at start+257.
- Lane values 255, 256, 0xFFFF, 17 -> map_data lanes 255, 255, 255, 17.
- map_ready=0 for 10 cycles on line 5 -> map_valid stays 1; map_data and map_index=5 stable; no address change; proceeds on map_ready=1.
- Second start pulse at line 20 and another in the DONE cycle -> both ignored; exactly 64 lines and one rd_done.
- reset=0 during OUT_VALID of line 30 -> all outputs 0 immediately (asynchronous); after release, a new start reads from address 129, index 0.
- Random map_ready (50%) over a full run -> no lost or duplicated lines; data matches the preloaded memory image.
